// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: read-owner tag encoding and arbitration defaults.
package cpu_pkg;

  // Who issued the read that is currently in flight to the data memory.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DSP  = 2'd2
  } owner_e;

  localparam int unsigned STARVE_W       = 3;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Owner of the access granted this cycle; writes and loader grants return nothing.
  function automatic owner_e read_owner(input logic gnt_cpu, input logic cpu_we,
                                        input logic gnt_dsp);
    owner_e o;
    o = OWN_NONE;
    if (gnt_cpu && !cpu_we) o = OWN_CPU;
    else if (gnt_dsp)       o = OWN_DSP;
    return o;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector between the display reader and the switch loader.
// Ports:
//   clk, rst      clock, async active-low reset (history returns to dsp-first)
//   req_dsp       display reader request
//   req_ldr       switch loader request
//   allow         external grant permitted this cycle (CPU not taking the port)
//   sel_dsp_c     combinational grant to the display reader
//   sel_ldr_c     combinational grant to the switch loader
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_dsp,
  input  logic req_ldr,
  input  logic allow,
  output logic sel_dsp_c,
  output logic sel_ldr_c
);

  // Set when the display reader won the most recent external grant.
  logic last_dsp_q;

  // Contested cycles go to whoever did not win last time.
  always_comb begin
    sel_dsp_c = 1'b0;
    sel_ldr_c = 1'b0;
    if (allow) begin
      sel_dsp_c = req_dsp && (!req_ldr || !last_dsp_q);
      sel_ldr_c = req_ldr && (!req_dsp ||  last_dsp_q);
    end
  end

  // History only moves on an actual external grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dsp_q <= 1'b0;
    end else if (sel_dsp_c) begin
      last_dsp_q <= 1'b1;
    end else if (sel_ldr_c) begin
      last_dsp_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: CPU MEM stage has priority, display reader and switch
// loader share the leftover slots round-robin, with a starve counter that forces
// an external grant after STARVE_MAX consecutive waits behind the CPU.
// Ports:
//   clk, rst                        clock, async active-low reset
//   cpu_req/we/addr/wdata           CPU access request
//   cpu_stall                       CPU not served this cycle
//   cpu_rdata/cpu_rvalid            CPU read return (one cycle after grant)
//   dsp_req/addr, dsp_gnt           display read request and grant
//   dsp_rdata/dsp_rvalid            display read return
//   ldr_req/addr/wdata, ldr_gnt     loader write request and grant
//   mem_en/we/addr/wdata, mem_rdata single-port synchronous RAM interface
module dm_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW         = 5,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dsp_req,
  input  logic [AW-1:0] dsp_addr,
  output logic          dsp_gnt,
  output logic [DW-1:0] dsp_rdata,
  output logic          dsp_rvalid,
  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic                ext_pend;
  logic                starved;
  logic                gnt_cpu;
  logic                gnt_dsp;
  logic                gnt_ldr;
  logic                allow_ext;
  logic [STARVE_W-1:0] starve_q, starve_d;
  owner_e              owner_q, owner_d;
  logic [DW-1:0]       cpu_rdata_q;
  logic [DW-1:0]       dsp_rdata_q;

  // CPU wins unless an external requester has waited STARVE_MAX cycles.
  // Gating with rst forces every grant low while reset is held.
  always_comb begin
    ext_pend  = dsp_req || ldr_req;
    starved   = ext_pend && (starve_q == STARVE_W'(STARVE_MAX));
    gnt_cpu   = rst && cpu_req && !starved;
    allow_ext = rst && !gnt_cpu;
  end

  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_dsp   (dsp_req),
    .req_ldr   (ldr_req),
    .allow     (allow_ext),
    .sel_dsp_c (gnt_dsp),
    .sel_ldr_c (gnt_ldr)
  );

  // RAM command mux; idle cycles drive an all-zero command.
  always_comb begin
    mem_en    = gnt_cpu || gnt_dsp || gnt_ldr;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_cpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt_dsp) begin
      mem_addr  = dsp_addr;
    end else if (gnt_ldr) begin
      mem_we    = 1'b1;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  // Starve counter: counts waits behind the CPU, saturates, clears on external grant.
  always_comb begin
    starve_d = starve_q;
    if (gnt_dsp || gnt_ldr) begin
      starve_d = '0;
    end else if (ext_pend && (starve_q != STARVE_W'(STARVE_MAX))) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    owner_d = read_owner(gnt_cpu, cpu_we, gnt_dsp);
  end

  // Owner tag and return-data holding registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      dsp_rdata_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      if (owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
      if (owner_q == OWN_DSP) dsp_rdata_q <= mem_rdata;
    end
  end

  // Return path: RAM data passes straight through in the strobe cycle, held after.
  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign dsp_rvalid = (owner_q == OWN_DSP);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dsp_rdata  = dsp_rvalid ? mem_rdata : dsp_rdata_q;
  assign cpu_stall  = rst && cpu_req && !gnt_cpu;
  assign dsp_gnt    = gnt_dsp;
  assign ldr_gnt    = gnt_ldr;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 32-word synchronous RAM.
module tb_dm_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          dsp_req;
  logic [AW-1:0] dsp_addr;
  logic          dsp_gnt;
  logic [DW-1:0] dsp_rdata;
  logic          dsp_rvalid;
  logic          ldr_req;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_gnt;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [32];

  int n_checks = 0;
  int n_fail   = 0;

  dm_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dsp_req    (dsp_req),
    .dsp_addr   (dsp_addr),
    .dsp_gnt    (dsp_gnt),
    .dsp_rdata  (dsp_rdata),
    .dsp_rvalid (dsp_rvalid),
    .ldr_req    (ldr_req),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: preload, then one access per enabled cycle.
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = DW'(0);
    ram[1]    = 32'h2A;
    ram[2]    = 32'h11;
    ram[3]    = 32'h33;
    ram[4]    = 32'h44;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dsp_req = 1'b0; dsp_addr = '0;
    ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    // Reset state
    @(negedge clk);
    chk("rst_stall",     cpu_stall,  1'b0);
    chk("rst_mem_en",    mem_en,     1'b0);
    chk("rst_cpu_rv",    cpu_rvalid, 1'b0);
    chk("rst_dsp_rv",    dsp_rvalid, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata,  32'h0);
    chk("rst_dsp_rdata", dsp_rdata,  32'h0);
    next_cycle();
    rst = 1'b1;

    // CPU read of addr 1 alone
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 5'd1;
    @(negedge clk);
    chk("a_mem_en",   mem_en,    1'b1);
    chk("a_mem_we",   mem_we,    1'b0);
    chk("a_mem_addr", mem_addr,  5'd1);
    chk("a_stall",    cpu_stall, 1'b0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("a_rvalid",   cpu_rvalid, 1'b1);
    chk("a_rdata",    cpu_rdata,  32'h2A);
    chk("a_idle_en",  mem_en,     1'b0);
    next_cycle();
    @(negedge clk);
    chk("a_rvalid_off", cpu_rvalid, 1'b0);
    chk("a_rdata_hold", cpu_rdata,  32'h2A);

    // dsp and ldr both requesting, no CPU: alternation starting with dsp
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 0) begin
        dsp_req = 1'b1; dsp_addr = 5'd4;
        ldr_req = 1'b1; ldr_addr = 5'd10; ldr_wdata = 32'h77;
      end
      @(negedge clk);
      chk($sformatf("rr_dsp_gnt_%0d", i), dsp_gnt, (i % 2) == 0);
      chk($sformatf("rr_ldr_gnt_%0d", i), ldr_gnt, (i % 2) == 1);
      chk($sformatf("rr_mem_we_%0d", i),  mem_we,  (i % 2) == 1);
      chk($sformatf("rr_dsp_rv_%0d", i),  dsp_rvalid, (i % 2) == 1);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("rr_dsp_rdata", dsp_rdata, 32'h44);
    chk("rr_idle_en",   mem_en,    1'b0);

    // CPU and dsp held: dsp forced through on the 5th cycle, then again 5 later
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (i == 0) begin
        cpu_req = 1'b1; cpu_addr = 5'd3;
        dsp_req = 1'b1; dsp_addr = 5'd4;
      end
      @(negedge clk);
      chk($sformatf("st_dsp_gnt_%0d", i), dsp_gnt,    (i == 4) || (i == 9));
      chk($sformatf("st_stall_%0d", i),   cpu_stall,  (i == 4) || (i == 9));
      chk($sformatf("st_dsp_rv_%0d", i),  dsp_rvalid, i == 5);
      chk($sformatf("st_cpu_rv_%0d", i),  cpu_rvalid, (i >= 1) && (i != 5));
    end
    chk("st_dsp_rdata_held", dsp_rdata, 32'h44);
    chk("st_cpu_rdata",      cpu_rdata, 32'h33);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("st_last_dsp_rv", dsp_rvalid, 1'b1);
    chk("st_last_rdata",  dsp_rdata,  32'h44);

    // Loader write then CPU read of the same address
    next_cycle();
    ldr_req = 1'b1; ldr_addr = 5'd2; ldr_wdata = 32'h55;
    @(negedge clk);
    chk("w_ldr_gnt",  ldr_gnt,   1'b1);
    chk("w_mem_we",   mem_we,    1'b1);
    chk("w_mem_addr", mem_addr,  5'd2);
    chk("w_mem_wd",   mem_wdata, 32'h55);
    next_cycle();
    ldr_req = 1'b0;
    cpu_req = 1'b1; cpu_addr = 5'd2;
    @(negedge clk);
    chk("w_cpu_en",   mem_en,    1'b1);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("w_rv",    cpu_rvalid, 1'b1);
    chk("w_rdata", cpu_rdata,  32'h55);

    // Same-address CPU read and loader write in one cycle: CPU first, old data
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 5'd2;
    ldr_req = 1'b1; ldr_addr = 5'd2; ldr_wdata = 32'h66;
    @(negedge clk);
    chk("c_stall",   cpu_stall, 1'b0);
    chk("c_ldr_gnt", ldr_gnt,   1'b0);
    chk("c_mem_we",  mem_we,    1'b0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("c_ldr_gnt2", ldr_gnt,   1'b1);
    chk("c_rdata_old", cpu_rdata, 32'h55);
    next_cycle();
    ldr_req = 1'b0;
    cpu_req = 1'b1; cpu_addr = 5'd2;
    @(negedge clk);
    chk("c_cpu_en", mem_en, 1'b1);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("c_rdata_new", cpu_rdata, 32'h66);
    next_cycle();
    @(negedge clk);
    chk("c_idle_en",    mem_en,    1'b0);
    chk("c_rdata_hold", cpu_rdata, 32'h66);

    // Reset right after a dsp read grant: its data must never be delivered
    next_cycle();
    dsp_req = 1'b1; dsp_addr = 5'd4;
    @(negedge clk);
    chk("r_dsp_gnt", dsp_gnt, 1'b1);
    next_cycle();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 5'd1;
    @(negedge clk);
    chk("r_dsp_rv",    dsp_rvalid, 1'b0);
    chk("r_dsp_gnt0",  dsp_gnt,    1'b0);
    chk("r_stall0",    cpu_stall,  1'b0);
    chk("r_mem_en0",   mem_en,     1'b0);
    chk("r_mem_addr0", mem_addr,   5'd0);
    chk("r_cpu_rv0",   cpu_rvalid, 1'b0);
    chk("r_dsp_rdata", dsp_rdata,  32'h0);
    chk("r_cpu_rdata", cpu_rdata,  32'h0);
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("r_post_dsp_rv", dsp_rvalid, 1'b0);
    chk("r_post_rdata",  dsp_rdata,  32'h0);
    next_cycle();
    @(negedge clk);
    chk("r_post_dsp_rv2", dsp_rvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter AW, default 5, meaning data-memory word-address width (32 words).
REQ-002 SHALL have parameter DW, default 32, meaning data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive cycles an external requester waits behind the CPU.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cpu_req / cpu_we  in  1/1  MEM-stage access request / write select.
REQ-007 cpu_addr / cpu_wdata  in  AW/DW  MEM-stage address / write data.
REQ-008 cpu_stall  out  1  CPU request not served this cycle; pipeline holds the MEM stage.
REQ-009 cpu_rdata / cpu_rvalid  out  DW/1  CPU read data / one-cycle valid strobe.
REQ-010 dsp_req / dsp_addr  in  1/AW  display-reader read request / address.
REQ-011 dsp_gnt / dsp_rdata / dsp_rvalid  out  1/DW/1  display grant / read data / valid strobe.
REQ-012 ldr_req / ldr_addr / ldr_wdata  in  1/AW/DW  switch-loader write request / address / data.
REQ-013 ldr_gnt  out  1  switch-loader write accepted.
REQ-014 mem_en / mem_we / mem_addr / mem_wdata  out  1/1/AW/DW  single-port synchronous RAM control.
REQ-015 mem_rdata  in  DW  RAM read data, valid one cycle after a read enable.

Function
REQ-016 SHALL grant at most one requester per cycle; the grant decision is combinational from current requests and registered state.
REQ-017 SHALL grant the CPU whenever cpu_req=1, unless the starve counter equals STARVE_MAX and an external request is pending.
REQ-018 SHALL choose between dsp and ldr by round-robin: the requester not granted last wins; on a tie with no history, dsp wins.
REQ-019 SHALL assert cpu_stall=1 exactly in cycles where cpu_req=1 and the CPU is not granted.
REQ-020 SHALL keep dsp_gnt/ldr_gnt high for one cycle per accepted access; requesters hold req and payload until they see gnt.
REQ-021 SHALL drive mem_en=1 in any granted cycle, with mem_we=cpu_we for the CPU, 0 for dsp, and 1 for ldr.
REQ-022 SHALL register the owner of each granted read (2-bit tag NONE/CPU/DSP).
REQ-023 SHALL, one cycle after the read is granted, route mem_rdata to the owner's rdata and pulse its rvalid for one cycle (read latency 1).
REQ-024 SHALL hold cpu_rdata and dsp_rdata stable between strobes.
REQ-025 SHALL increment the 3-bit starve counter each cycle an external request is pending and not granted.
REQ-026 SHALL saturate the starve counter at STARVE_MAX and clear it on any external grant.
REQ-027 SHALL, on same-address CPU read plus ldr write in one cycle, serve them in grant order; the read that follows a write returns the new data.
REQ-028 SHALL drive mem_en=0 and leave counters and round-robin history unchanged when no request is present.

Reset
REQ-029 SHALL, on rst=0, immediately clear all gnt, rvalid, stall and mem_en outputs, rdata registers (0), the owner tag (NONE), the starve counter (0) and round-robin history (dsp first).
REQ-030 SHALL discard any read in flight at reset assertion and never deliver its data.

Structure
REQ-031 SHALL take the owner-tag encoding and STARVE_MAX default from the shared cpu_pkg package.
REQ-032 SHALL place the dsp/ldr round-robin selector and its history bit in one sub-module, rr_arb2.

Verification
REQ-033 Verify: CPU read addr 1 alone, DM[1]=0x2A -> mem_en=1 in cycle 0; cpu_rvalid=1 with cpu_rdata=0x2A in cycle 1; cpu_stall=0.
REQ-034 Verify: cpu_req and dsp_req held continuously -> dsp_gnt in the 5th cycle, cpu_stall=1 only in that cycle, counter back to 0.
REQ-035 Verify: dsp_req and ldr_req continuous, no CPU -> grants alternate dsp, ldr, dsp, ldr.
REQ-036 Verify: ldr write 0x55 to addr 2 granted, then CPU read addr 2 -> cpu_rdata=0x55.
REQ-037 Verify: rst asserted in the cycle after a dsp read grant -> dsp_rvalid never pulses and all outputs are 0 during reset.
